// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Scan state encoding plus column-vector utilities.
package keypad_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    SAMPLE,
    DEBOUNCE,
    EMIT,
    HOLD,
    RELEASE
  } scan_state_t;

  function automatic logic [1:0] onehot4_to_idx(
    input logic [3:0] v
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(
    input logic [3:0] v
  );
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchroniser for the raw keypad columns.
// Cleared asynchronously so no stale press survives reset.
module col_sync (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] s1;

  // two-stage metastability filter
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row strobe, settle/debounce timing and key events
// for a 4x4 matrix keypad with optional auto-repeat.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_err
);

  import keypad_pkg::*;

  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit RPT_EN = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [3:0]       cols_s;
  scan_state_t      state;
  logic [CNT_W-1:0] timer;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [1:0]       next_row;
  logic [3:0]       col_oh;
  logic             col_on;

  col_sync u_sync (
    .clk   (clk),
    .clr_n (reset),
    .d     (cols),
    .q     (cols_s)
  );

  assign next_row = row_idx + 2'd1;
  assign col_oh   = 4'b0001 << col_idx;
  assign col_on   = |(cols_s & col_oh);

  // scan FSM with timer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SETTLE;
      timer     <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      rows      <= 4'b0001;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      unique case (state)
        SETTLE: begin
          if (timer == SET_LAST) begin
            state <= SAMPLE;
            timer <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end
        SAMPLE: begin
          if (cols_s == 4'd0 || multi_hot(cols_s)) begin
            multi_err <= multi_hot(cols_s);
            row_idx   <= next_row;
            rows      <= 4'b0001 << next_row;
            state     <= SETTLE;
            timer     <= '0;
          end else begin
            col_idx <= onehot4_to_idx(cols_s);
            state   <= DEBOUNCE;
            timer   <= '0;
          end
        end
        DEBOUNCE: begin
          if (timer != DB_LAST) begin
            timer <= timer + ONE;
          end else if (cols_s == col_oh) begin
            key_valid <= 1'b1;
            key_code  <= {row_idx, col_idx};
            state     <= EMIT;
            timer     <= '0;
          end else begin
            row_idx <= next_row;
            rows    <= 4'b0001 << next_row;
            state   <= SETTLE;
            timer   <= '0;
          end
        end
        EMIT: begin
          key_held <= 1'b1;
          state    <= HOLD;
          timer    <= '0;
        end
        HOLD: begin
          if (!col_on) begin
            state <= RELEASE;
            timer <= '0;
          end else if (RPT_EN) begin
            if (timer == RPT_LAST) begin
              key_valid <= 1'b1;
              timer     <= '0;
            end else begin
              timer <= timer + ONE;
            end
          end
        end
        RELEASE: begin
          if (col_on) begin
            state <= HOLD;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            key_held <= 1'b0;
            row_idx  <= next_row;
            rows     <= 4'b0001 << next_row;
            state    <= SETTLE;
            timer    <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end
        default: begin
          state <= SETTLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl.
// Models the key matrix; events are queued at press time.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_err;

  logic [15:0] pressed = '0;
  logic [3:0]  kv_q[$];
  logic [3:0]  me_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // matrix: a pressed key connects its row to its column
  always_comb begin
    cols = '0;
    for (int r = 0; r < 4; r++) begin
      if (rows[r]) cols = cols | pressed[r*4 +: 4];
    end
  end

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (3),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (10),
    .CNT_W           (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_rows(input logic [3:0] r);
    int n = 0;
    while (rows !== r && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rows", 32'(rows), 32'(r));
  endtask

  task automatic wait_fresh(input logic [3:0] r);
    int n = 0;
    while (rows === r && n < 300) begin
      @(negedge clk);
      n++;
    end
    wait_rows(r);
  endtask

  task automatic wait_held(input logic v);
    int n = 0;
    while (key_held !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_held", 32'(key_held), 32'(v));
  endtask

  // pop expected events as the DUT produces them
  always @(negedge clk) begin
    if (reset) begin
      if (key_valid || multi_err)
        chk("kv_me_excl", 32'(key_valid & multi_err), 0);
      if (key_valid) begin
        if (kv_q.size() == 0)
          chk("kv_unexp", 32'(key_valid), 0);
        else
          chk("kv_code", 32'(key_code),
              32'(kv_q.pop_front()));
      end
      if (multi_err) begin
        if (me_q.size() == 0)
          chk("me_unexp", 32'(multi_err), 0);
        else
          chk("me_rows", 32'(rows),
              32'(me_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    logic [3:0] er;

    repeat (3) @(negedge clk);
    chk("rst_rows", 32'(rows), 32'h1);
    chk("rst_kv", 32'(key_valid), 0);
    chk("rst_kc", 32'(key_code), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_me", 32'(multi_err), 0);
    reset = 1'b1;

    // idle scan: each row for 4 cycles
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      er = 4'(1 << ((k / 4) % 4));
      chk("idle_rows", 32'(rows), 32'(er));
    end

    // clean press row 1 / col 2
    wait_fresh(4'b0010);
    pressed[6] = 1'b1;
    kv_q.push_back(4'h6);
    wait_held(1'b1);
    repeat (3) @(negedge clk);
    chk("hold_rows", 32'(rows), 32'h2);
    pressed[6] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_held && n < 50);
    chk("rel_cycles", 32'(n), 7);
    chk("rel_rows", 32'(rows), 32'h4);
    chk("kc_keep", 32'(key_code), 32'h6);

    // bounce on row 0
    wait_fresh(4'b0001);
    @(negedge clk);
    pressed[0] = 1'b1;
    repeat (2) @(negedge clk);
    pressed[0] = 1'b0;
    n = 0;
    while (rows === 4'b0001 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bnc_cycles", 32'(n), 5);
    chk("bnc_rows", 32'(rows), 32'h2);
    chk("bnc_held", 32'(key_held), 0);

    // two keys on row 3
    wait_fresh(4'b1000);
    pressed[13:12] = 2'b11;
    me_q.push_back(4'b0001);
    n = 0;
    while (!multi_err && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("me_seen", 32'(multi_err), 1);
    chk("me_lat", 32'(n), 4);
    chk("me_wrap", 32'(rows), 32'h1);
    pressed[13:12] = 2'b00;

    // auto-repeat with a release glitch
    wait_fresh(4'b0010);
    pressed[6] = 1'b1;
    repeat (4) kv_q.push_back(4'h6);
    wait_held(1'b1);
    repeat (34) @(negedge clk);
    pressed[6] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("glitch_held", 32'(key_held), 1);
    end
    pressed[6] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("regrab_held", 32'(key_held), 1);
    end
    pressed[6] = 1'b0;
    wait_held(1'b0);
    chk("rpt_rows", 32'(rows), 32'h4);

    // reset during debounce
    wait_fresh(4'b0100);
    pressed[9] = 1'b1;
    repeat (5) @(negedge clk);
    chk("dbn_rows", 32'(rows), 32'h4);
    reset = 1'b0;
    #1;
    chk("mid_rows", 32'(rows), 32'h1);
    chk("mid_kv", 32'(key_valid), 0);
    chk("mid_kc", 32'(key_code), 0);
    chk("mid_held", 32'(key_held), 0);
    chk("mid_me", 32'(multi_err), 0);
    pressed[9] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("post_rows", 32'(rows), 32'h1);
    repeat (30) @(negedge clk);

    chk("kv_left", 32'(kv_q.size()), 0);
    chk("me_left", 32'(me_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
